cmat_addr_seq: RTL and testbench
================================

CMAT_ADDR_SEQ -- requirements
Module: cmat_addr_seq

Interface
REQ-001 SHALL have parameter NBIT, default 32, width of the accumulator result word (signed, Q11.21).
REQ-002 SHALL have parameter DIM, default 3, square matrix dimension; DIM >= 2.
REQ-003 SHALL have parameter ADDRESS, default $clog2(2*DIM*DIM), memory address width (5 for DIM=3).
REQ-004 clk_seq  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_seq  input  1  asynchronous, active-low reset.
REQ-006 start_seq  input  1  one-cycle pulse; begins a full C = A x B pass; ignored unless IDLE.
REQ-007 step_seq  input  1  clock-enable strobe; each high cycle advances the sequence by one MAC term.
REQ-008 addr_ar_seq / addr_ai_seq  output  ADDRESS each  A-memory addresses, real / imaginary part.
REQ-009 addr_br_seq / addr_bi_seq  output  ADDRESS each  B-memory addresses, real / imaginary part.
REQ-010 ena_seq  output  1  MAC enable; high for one cycle per issued term.
REQ-011 clr_seq  output  1  accumulator clear; high with the first term (j=0) of each dot product.
REQ-012 flag_seq  input  1  datapath pulse: acc_seq holds a finished element.
REQ-013 acc_seq  input  NBIT  signed finished element from the complex MAC.
REQ-014 res_data_seq  output  NBIT  captured element; res_row_seq, res_col_seq  output  $clog2(DIM) each, its indices.
REQ-015 res_valid_seq  output  1 / res_ready_seq  input  1  result handshake; transfer when both high.
REQ-016 busy_seq, done_seq, ovf_seq  output  1 each  pass active / one-cycle pass-complete pulse / sticky overrun.

Function
REQ-017 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-018 IDLE->RUN on start_seq; RUN->DRAIN after the DIM^3-th step is issued; DRAIN->DONE when DIM*DIM results are transferred; DONE->IDLE after one cycle.
REQ-019 SHALL hold nested counters i (A row, outer), h (B column, middle), j (inner), all starting at 0; j wraps at DIM-1 and increments h; h wraps and increments i.
REQ-020 Per step SHALL drive addr_ar=2*(i*DIM+j), addr_ai=addr_ar+1, addr_br=2*(h*DIM+j), addr_bi=addr_br+1.
REQ-021 Addresses, ena_seq and clr_seq SHALL be registered; they become valid one clk_seq cycle after the accepted step_seq (latency 1).
REQ-022 ena_seq SHALL be low in every cycle that does not follow an accepted step; step_seq outside RUN SHALL be ignored.
REQ-023 Addresses SHALL hold their last value while ena_seq is low.
REQ-024 Result capture SHALL track a separate write index (row, col) from 0,0 in i-then-h order, independent of the issue counters.
REQ-025 On flag_seq with res_valid_seq low, SHALL latch acc_seq plus indices and set res_valid_seq the next cycle.
REQ-026 res_valid_seq SHALL stay high with stable data until res_ready_seq; flag and transfer in the same cycle SHALL reload without a bubble.
REQ-027 flag_seq while valid is held and not transferring SHALL set ovf_seq and drop the new value; the write index does not advance.
REQ-028 flag_seq in IDLE or DONE SHALL be ignored.
REQ-029 busy_seq SHALL be high in RUN and DRAIN.

Reset
REQ-030 On rst_seq low, SHALL go to IDLE and clear all counters, addresses, ena_seq, clr_seq, res_valid_seq, res_data_seq, indices, done_seq and ovf_seq to 0, asynchronously.
REQ-031 Reset mid-pass SHALL abandon the pass; the next start_seq restarts from i=h=j=0.
REQ-032 ovf_seq SHALL clear only by reset or by start_seq.

Structure
REQ-033 State encoding, the Q-format field widths (Q5.27 operands, Q11.21 accumulator) and the address function SHALL live in the shared matrix package.
REQ-034 The result holding register with valid/ready SHALL be one sub-module, cmat_res_buf.

Verification
REQ-035 DIM=3, start then step every cycle: first term ar=0,ai=1,br=0,bi=1 with clr=1; (i=0,h=1,j=2) gives ar=4,ai=5,br=10,bi=11; last term ar=16,br=16; exactly 27 ena pulses.
REQ-036 step_seq every 4th cycle: ena pulses exactly 1 cycle after each step, addresses stable in between, clr on terms 1,4,7,...
REQ-037 9 flag pulses with acc=32'h0000_0001..9, ready=1: 9 transfers, indices (0,0),(0,1)...(2,2), data in order, done_seq one cycle after the 9th transfer.
REQ-038 ready=0, two flags: first value held, ovf_seq=1, second dropped; ready=1 then transfers the first value.
REQ-039 rst_seq low after 10 steps: all outputs 0 immediately; new start reproduces REQ-035 from ar=0.
REQ-040 start_seq and step_seq during RUN or DRAIN: no counter restart, sequence unchanged.

Source files
------------

// File: rtl/cmat_addr_seq_pkg.sv
// Shared types, Q-format field widths and the address mapping for the complex
// matrix multiply sequencer.
package cmat_addr_seq_pkg;

    localparam int unsigned OP_INT_BITS   = 5;
    localparam int unsigned OP_FRAC_BITS  = 27;
    localparam int unsigned OP_W          = OP_INT_BITS + OP_FRAC_BITS;
    localparam int unsigned ACC_INT_BITS  = 11;
    localparam int unsigned ACC_FRAC_BITS = 21;
    localparam int unsigned ACC_W         = ACC_INT_BITS + ACC_FRAC_BITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    // Complex elements are stored as a real word followed by its imaginary word.
    function automatic int unsigned elem_addr(input int unsigned row,
                                              input int unsigned col,
                                              input int unsigned dim);
        return 2 * (row * dim + col);
    endfunction

endpackage

// File: rtl/cmat_addr_seq_if.sv
// Control, address and result-handshake bundle between the sequencer and the
// matrix datapath / result consumer.
interface cmat_addr_seq_if #(
    parameter int unsigned NBIT    = cmat_addr_seq_pkg::ACC_W,
    parameter int unsigned DIM     = 3,
    parameter int unsigned ADDRESS = $clog2(2 * DIM * DIM)
) ();
    localparam int unsigned IW = $clog2(DIM);

    logic                   start_seq;
    logic                   step_seq;
    logic [ADDRESS-1:0]     addr_ar_seq;
    logic [ADDRESS-1:0]     addr_ai_seq;
    logic [ADDRESS-1:0]     addr_br_seq;
    logic [ADDRESS-1:0]     addr_bi_seq;
    logic                   ena_seq;
    logic                   clr_seq;
    logic                   flag_seq;
    logic signed [NBIT-1:0] acc_seq;
    logic signed [NBIT-1:0] res_data_seq;
    logic [IW-1:0]          res_row_seq;
    logic [IW-1:0]          res_col_seq;
    logic                   res_valid_seq;
    logic                   res_ready_seq;
    logic                   busy_seq;
    logic                   done_seq;
    logic                   ovf_seq;

    modport master (
        input  start_seq, step_seq, flag_seq, acc_seq, res_ready_seq,
        output addr_ar_seq, addr_ai_seq, addr_br_seq, addr_bi_seq,
               ena_seq, clr_seq, res_data_seq, res_row_seq, res_col_seq,
               res_valid_seq, busy_seq, done_seq, ovf_seq
    );

    modport slave (
        output start_seq, step_seq, flag_seq, acc_seq, res_ready_seq,
        input  addr_ar_seq, addr_ai_seq, addr_br_seq, addr_bi_seq,
               ena_seq, clr_seq, res_data_seq, res_row_seq, res_col_seq,
               res_valid_seq, busy_seq, done_seq, ovf_seq
    );

endinterface

// File: rtl/cmat_res_buf.sv
// Single-entry result holding register with valid/ready handshake, its own
// row-major write index and a sticky overrun flag.
module cmat_res_buf #(
    parameter int unsigned NBIT = 32,
    parameter int unsigned DIM  = 3,
    parameter int unsigned IW   = $clog2(DIM)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   restart,
    input  logic                   en,
    input  logic                   flag,
    input  logic signed [NBIT-1:0] acc,
    input  logic                   ready,
    output logic signed [NBIT-1:0] data,
    output logic [IW-1:0]          row,
    output logic [IW-1:0]          col,
    output logic                   valid,
    output logic                   ovf,
    output logic                   xfer_c
);

    logic [IW-1:0] wr_row_q;
    logic [IW-1:0] wr_col_q;
    logic          load_c;
    logic          drop_c;

    // A new element may enter when the slot is empty or is emptying this cycle.
    assign xfer_c = valid & ready;
    assign load_c = en & flag & (~valid | ready);
    assign drop_c = en & flag & valid & ~ready;

    // Holding register and handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            row   <= '0;
            col   <= '0;
            valid <= 1'b0;
        end else if (load_c) begin
            data  <= acc;
            row   <= wr_row_q;
            col   <= wr_col_q;
            valid <= 1'b1;
        end else if (xfer_c) begin
            valid <= 1'b0;
        end
    end

    // Write index advances only on accepted elements; dropped ones leave it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_row_q <= '0;
            wr_col_q <= '0;
        end else if (restart) begin
            wr_row_q <= '0;
            wr_col_q <= '0;
        end else if (load_c) begin
            if (wr_col_q == IW'(DIM - 1)) begin
                wr_col_q <= '0;
                wr_row_q <= (wr_row_q == IW'(DIM - 1)) ? '0 : wr_row_q + 1'b1;
            end else begin
                wr_col_q <= wr_col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (restart) begin
            ovf <= 1'b0;
        end else if (drop_c) begin
            ovf <= 1'b1;
        end
    end

endmodule

// File: rtl/cmat_addr_seq.sv
// Address/control sequencer for C = A x B on complex DIMxDIM matrices: issues one
// MAC term per step and collects finished elements through a result buffer.
module cmat_addr_seq
    import cmat_addr_seq_pkg::*;
#(
    parameter int unsigned NBIT    = ACC_W,
    parameter int unsigned DIM     = 3,
    parameter int unsigned ADDRESS = $clog2(2 * DIM * DIM)
) (
    input  logic            clk_seq,
    input  logic            rst_seq,
    cmat_addr_seq_if.master bus
);

    localparam int unsigned CW    = $clog2(DIM);
    localparam int unsigned TOTAL = DIM * DIM;
    localparam int unsigned XW    = $clog2(TOTAL + 1);

    seq_state_e         state_q, state_d;
    logic [CW-1:0]      i_q, i_d;
    logic [CW-1:0]      h_q, h_d;
    logic [CW-1:0]      j_q, j_d;
    logic [ADDRESS-1:0] ar_q, ar_d;
    logic [ADDRESS-1:0] ai_q, ai_d;
    logic [ADDRESS-1:0] br_q, br_d;
    logic [ADDRESS-1:0] bi_q, bi_d;
    logic               ena_q, ena_d;
    logic               clr_q, clr_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic [XW-1:0]      xfer_cnt_q, xfer_cnt_d;
    logic               start_acc_c;
    logic               last_term_c;
    logic               buf_xfer_c;

    // Next-state, counter and issue logic.
    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        h_d         = h_q;
        j_d         = j_q;
        ar_d        = ar_q;
        ai_d        = ai_q;
        br_d        = br_q;
        bi_d        = bi_q;
        ena_d       = 1'b0;
        clr_d       = 1'b0;
        done_d      = 1'b0;
        xfer_cnt_d  = xfer_cnt_q;
        start_acc_c = 1'b0;
        last_term_c = (i_q == CW'(DIM - 1)) && (h_q == CW'(DIM - 1)) && (j_q == CW'(DIM - 1));

        if (busy_q && buf_xfer_c && (xfer_cnt_q < XW'(TOTAL))) begin
            xfer_cnt_d = xfer_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.start_seq) begin
                    state_d     = ST_RUN;
                    i_d         = '0;
                    h_d         = '0;
                    j_d         = '0;
                    xfer_cnt_d  = '0;
                    start_acc_c = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.step_seq) begin
                    ena_d = 1'b1;
                    clr_d = (j_q == '0);
                    ar_d  = ADDRESS'(elem_addr(32'(i_q), 32'(j_q), DIM));
                    ai_d  = ar_d + ADDRESS'(1);
                    br_d  = ADDRESS'(elem_addr(32'(h_q), 32'(j_q), DIM));
                    bi_d  = br_d + ADDRESS'(1);
                    // j innermost, then h (B column), then i (A row).
                    if (j_q == CW'(DIM - 1)) begin
                        j_d = '0;
                        if (h_q == CW'(DIM - 1)) begin
                            h_d = '0;
                            i_d = (i_q == CW'(DIM - 1)) ? '0 : i_q + 1'b1;
                        end else begin
                            h_d = h_q + 1'b1;
                        end
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                    if (last_term_c) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (xfer_cnt_d >= XW'(TOTAL)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    end

    always_ff @(posedge clk_seq or negedge rst_seq) begin
        if (!rst_seq) begin
            state_q    <= ST_IDLE;
            i_q        <= '0;
            h_q        <= '0;
            j_q        <= '0;
            ar_q       <= '0;
            ai_q       <= '0;
            br_q       <= '0;
            bi_q       <= '0;
            ena_q      <= 1'b0;
            clr_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            xfer_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            h_q        <= h_d;
            j_q        <= j_d;
            ar_q       <= ar_d;
            ai_q       <= ai_d;
            br_q       <= br_d;
            bi_q       <= bi_d;
            ena_q      <= ena_d;
            clr_q      <= clr_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign bus.addr_ar_seq = ar_q;
    assign bus.addr_ai_seq = ai_q;
    assign bus.addr_br_seq = br_q;
    assign bus.addr_bi_seq = bi_q;
    assign bus.ena_seq     = ena_q;
    assign bus.clr_seq     = clr_q;
    assign bus.done_seq    = done_q;
    assign bus.busy_seq    = busy_q;

    // Flags are only honoured while a pass is active.
    cmat_res_buf #(
        .NBIT (NBIT),
        .DIM  (DIM),
        .IW   (CW)
    ) u_res_buf (
        .clk     (clk_seq),
        .rst_n   (rst_seq),
        .restart (start_acc_c),
        .en      (busy_q),
        .flag    (bus.flag_seq),
        .acc     (bus.acc_seq),
        .ready   (bus.res_ready_seq),
        .data    (bus.res_data_seq),
        .row     (bus.res_row_seq),
        .col     (bus.res_col_seq),
        .valid   (bus.res_valid_seq),
        .ovf     (bus.ovf_seq),
        .xfer_c  (buf_xfer_c)
    );

endmodule

// File: tb/tb_cmat_addr_seq.sv
// Scenario bench for cmat_addr_seq: issue order, step pacing, result handshake,
// overrun and reset behaviour against a small reference model.
module tb_cmat_addr_seq;

    localparam int NBIT = 32;
    localparam int DIM  = 3;
    localparam int AW   = 5;
    localparam int IW   = 2;

    typedef struct {
        logic [AW-1:0] ar;
        logic [AW-1:0] ai;
        logic [AW-1:0] br;
        logic [AW-1:0] bi;
        logic          clr;
    } term_t;

    typedef struct {
        logic [NBIT-1:0] data;
        logic [IW-1:0]   row;
        logic [IW-1:0]   col;
    } res_t;

    logic  clkslow_tb = 1'b0;
    logic  rst_n_tb   = 1'b0;
    int    errors     = 0;
    int    checks     = 0;
    term_t term_q[$];
    res_t  res_q[$];
    int    mi, mh, mj;

    cmat_addr_seq_if #(.NBIT(NBIT), .DIM(DIM), .ADDRESS(AW)) bus ();

    cmat_addr_seq #(.NBIT(NBIT), .DIM(DIM), .ADDRESS(AW)) dut (
        .clk_seq (clkslow_tb),
        .rst_seq (rst_n_tb),
        .bus     (bus.master)
    );

    always #5 clkslow_tb = ~clkslow_tb;

    task automatic model_restart();
        mi = 0; mh = 0; mj = 0;
        term_q.delete();
        res_q.delete();
    endtask

    // Reference issue order: j innermost, then h, then i.
    task automatic push_term();
        term_t t;
        int a, b;
        a = 2 * (mi * DIM + mj);
        b = 2 * (mh * DIM + mj);
        t.ar = AW'(a); t.ai = AW'(a + 1);
        t.br = AW'(b); t.bi = AW'(b + 1);
        t.clr = (mj == 0);
        term_q.push_back(t);
        if (mj == DIM - 1) begin
            mj = 0;
            if (mh == DIM - 1) begin mh = 0; mi++; end
            else mh++;
        end else mj++;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({bus.ena_seq, bus.clr_seq, bus.busy_seq, bus.done_seq, bus.ovf_seq, bus.res_valid_seq} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ena=%b clr=%b busy=%b done=%b ovf=%b valid=%b, want all 0",
                     bus.ena_seq, bus.clr_seq, bus.busy_seq, bus.done_seq, bus.ovf_seq, bus.res_valid_seq);
        end
        checks++;
        if ({bus.addr_ar_seq, bus.addr_ai_seq, bus.addr_br_seq, bus.addr_bi_seq} !== 20'b0) begin
            errors++;
            $display("FAIL reset_addr: ar=%0d ai=%0d br=%0d bi=%0d, want 0", bus.addr_ar_seq,
                     bus.addr_ai_seq, bus.addr_br_seq, bus.addr_bi_seq);
        end
        checks++;
        if (bus.res_data_seq !== 32'sd0 || bus.res_row_seq !== 2'd0 || bus.res_col_seq !== 2'd0) begin
            errors++;
            $display("FAIL reset_res: data=%h row=%0d col=%0d, want 0", bus.res_data_seq,
                     bus.res_row_seq, bus.res_col_seq);
        end
        @(negedge clkslow_tb);
        rst_n_tb = 1'b1;
        // Steps and flags while idle must have no effect.
        bus.step_seq = 1'b1; bus.flag_seq = 1'b1; bus.acc_seq = 32'sh55;
        for (int k = 0; k < 3; k++) begin
            @(negedge clkslow_tb);
            checks++;
            if (bus.ena_seq !== 1'b0 || bus.busy_seq !== 1'b0 || bus.res_valid_seq !== 1'b0) begin
                errors++;
                $display("FAIL idle_ignore_%0d: ena=%b busy=%b valid=%b, want 0 0 0", k,
                         bus.ena_seq, bus.busy_seq, bus.res_valid_seq);
            end
        end
        bus.step_seq = 1'b0; bus.flag_seq = 1'b0;
    endtask

    task automatic test_full_pass();
        term_t t;
        int ena_cnt = 0;
        model_restart();
        @(negedge clkslow_tb); bus.start_seq = 1'b1;
        @(negedge clkslow_tb); bus.start_seq = 1'b0;
        for (int k = 0; k < 27; k++) begin
            bus.step_seq  = 1'b1;
            bus.start_seq = (k == 10);
            push_term();
            @(negedge clkslow_tb);
            if (bus.ena_seq === 1'b1) ena_cnt++;
            t = term_q.pop_front();
            checks++;
            if (bus.ena_seq !== 1'b1 || bus.clr_seq !== t.clr || bus.addr_ar_seq !== t.ar ||
                bus.addr_ai_seq !== t.ai || bus.addr_br_seq !== t.br || bus.addr_bi_seq !== t.bi) begin
                errors++;
                $display("FAIL full_term_%0d: ena=%b clr=%b ar=%0d ai=%0d br=%0d bi=%0d, want 1 %b %0d %0d %0d %0d",
                         k, bus.ena_seq, bus.clr_seq, bus.addr_ar_seq, bus.addr_ai_seq, bus.addr_br_seq,
                         bus.addr_bi_seq, t.clr, t.ar, t.ai, t.br, t.bi);
            end
            if (k == 0) begin
                checks++;
                if (bus.clr_seq !== 1'b1 || bus.addr_ar_seq !== 5'd0 || bus.addr_ai_seq !== 5'd1 ||
                    bus.addr_br_seq !== 5'd0 || bus.addr_bi_seq !== 5'd1) begin
                    errors++;
                    $display("FAIL first_term: clr=%b ar=%0d ai=%0d br=%0d bi=%0d, want 1 0 1 0 1",
                             bus.clr_seq, bus.addr_ar_seq, bus.addr_ai_seq, bus.addr_br_seq, bus.addr_bi_seq);
                end
            end
            if (k == 5) begin
                checks++;
                if (bus.addr_ar_seq !== 5'd4 || bus.addr_ai_seq !== 5'd5 ||
                    bus.addr_br_seq !== 5'd10 || bus.addr_bi_seq !== 5'd11) begin
                    errors++;
                    $display("FAIL term_i0h1j2: ar=%0d ai=%0d br=%0d bi=%0d, want 4 5 10 11",
                             bus.addr_ar_seq, bus.addr_ai_seq, bus.addr_br_seq, bus.addr_bi_seq);
                end
            end
            if (k == 26) begin
                checks++;
                if (bus.addr_ar_seq !== 5'd16 || bus.addr_br_seq !== 5'd16) begin
                    errors++;
                    $display("FAIL last_term: ar=%0d br=%0d, want 16 16", bus.addr_ar_seq, bus.addr_br_seq);
                end
            end
        end
        bus.step_seq = 1'b0; bus.start_seq = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clkslow_tb);
            if (bus.ena_seq === 1'b1) ena_cnt++;
        end
        checks++;
        if (ena_cnt != 27 || bus.busy_seq !== 1'b1) begin
            errors++;
            $display("FAIL ena_count: pulses=%0d busy=%b, want 27 1", ena_cnt, bus.busy_seq);
        end
    endtask

    task automatic test_results();
        res_t r;
        int   sent = 0;
        int   got  = 0;
        bit   expect_done = 0;
        bit   finished = 0;
        bus.res_ready_seq = 1'b1;
        for (int cyc = 0; cyc < 40 && !finished; cyc++) begin
            if (sent < DIM * DIM) begin
                bus.flag_seq = 1'b1;
                bus.acc_seq  = NBIT'(sent + 1);
                r.data = NBIT'(sent + 1); r.row = IW'(sent / DIM); r.col = IW'(sent % DIM);
                res_q.push_back(r);
                sent++;
            end else bus.flag_seq = 1'b0;
            bus.step_seq = 1'b1;
            @(negedge clkslow_tb);
            checks++;
            if (bus.ena_seq !== 1'b0) begin
                errors++;
                $display("FAIL drain_step_ignored: ena=%b, want 0", bus.ena_seq);
            end
            if (expect_done) begin
                checks++;
                if (bus.done_seq !== 1'b1 || bus.busy_seq !== 1'b0) begin
                    errors++;
                    $display("FAIL done_pulse: done=%b busy=%b, want 1 0", bus.done_seq, bus.busy_seq);
                end
                finished = 1;
            end else if (bus.res_valid_seq === 1'b1) begin
                checks++;
                if (res_q.size() == 0) begin
                    errors++;
                    $display("FAIL result_%0d: unexpected valid data=%h", got, bus.res_data_seq);
                end else begin
                    r = res_q.pop_front();
                    if (bus.res_data_seq !== r.data || bus.res_row_seq !== r.row || bus.res_col_seq !== r.col) begin
                        errors++;
                        $display("FAIL result_%0d: data=%h row=%0d col=%0d, want %h %0d %0d", got,
                                 bus.res_data_seq, bus.res_row_seq, bus.res_col_seq, r.data, r.row, r.col);
                    end
                end
                got++;
                if (got == DIM * DIM) expect_done = 1;
            end
        end
        bus.flag_seq = 1'b0; bus.step_seq = 1'b0;
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL drain_timeout: transfers=%0d, want %0d then done", got, DIM * DIM);
        end
        @(negedge clkslow_tb);
        checks++;
        if (bus.done_seq !== 1'b0 || bus.busy_seq !== 1'b0 || bus.res_valid_seq !== 1'b0) begin
            errors++;
            $display("FAIL after_done: done=%b busy=%b valid=%b, want 0 0 0", bus.done_seq,
                     bus.busy_seq, bus.res_valid_seq);
        end
    endtask

    task automatic test_overflow();
        res_t r;
        model_restart();
        @(negedge clkslow_tb); bus.start_seq = 1'b1;
        @(negedge clkslow_tb); bus.start_seq = 1'b0;
        bus.res_ready_seq = 1'b0;
        bus.flag_seq = 1'b1; bus.acc_seq = 32'shAA;
        r.data = 32'hAA; r.row = 2'd0; r.col = 2'd0; res_q.push_back(r);
        @(negedge clkslow_tb);
        bus.acc_seq = 32'shBB;
        checks++;
        if (bus.res_valid_seq !== 1'b1 || bus.res_data_seq !== 32'shAA || bus.ovf_seq !== 1'b0) begin
            errors++;
            $display("FAIL ovf_first: valid=%b data=%h ovf=%b, want 1 aa 0", bus.res_valid_seq,
                     bus.res_data_seq, bus.ovf_seq);
        end
        @(negedge clkslow_tb);
        bus.flag_seq = 1'b0;
        checks++;
        if (bus.ovf_seq !== 1'b1 || bus.res_valid_seq !== 1'b1 || bus.res_data_seq !== 32'shAA) begin
            errors++;
            $display("FAIL ovf_set: ovf=%b valid=%b data=%h, want 1 1 aa", bus.ovf_seq,
                     bus.res_valid_seq, bus.res_data_seq);
        end
        @(negedge clkslow_tb);
        bus.res_ready_seq = 1'b1;
        r = res_q.pop_front();
        checks++;
        if (bus.res_valid_seq !== 1'b1 || bus.res_data_seq !== r.data ||
            bus.res_row_seq !== r.row || bus.res_col_seq !== r.col) begin
            errors++;
            $display("FAIL ovf_held: valid=%b data=%h row=%0d col=%0d, want 1 %h %0d %0d",
                     bus.res_valid_seq, bus.res_data_seq, bus.res_row_seq, bus.res_col_seq, r.data, r.row, r.col);
        end
        @(negedge clkslow_tb);
        checks++;
        if (bus.res_valid_seq !== 1'b0 || bus.ovf_seq !== 1'b1) begin
            errors++;
            $display("FAIL ovf_after_xfer: valid=%b ovf=%b, want 0 1", bus.res_valid_seq, bus.ovf_seq);
        end
        // Dropped element must not have consumed a write index.
        bus.flag_seq = 1'b1; bus.acc_seq = 32'shCC;
        r.data = 32'hCC; r.row = 2'd0; r.col = 2'd1; res_q.push_back(r);
        @(negedge clkslow_tb);
        bus.flag_seq = 1'b0;
        r = res_q.pop_front();
        checks++;
        if (bus.res_valid_seq !== 1'b1 || bus.res_data_seq !== r.data ||
            bus.res_row_seq !== r.row || bus.res_col_seq !== r.col) begin
            errors++;
            $display("FAIL ovf_index: valid=%b data=%h row=%0d col=%0d, want 1 %h %0d %0d",
                     bus.res_valid_seq, bus.res_data_seq, bus.res_row_seq, bus.res_col_seq, r.data, r.row, r.col);
        end
        @(negedge clkslow_tb);
    endtask

    task automatic test_reset_midpass();
        term_t t;
        model_restart();
        for (int k = 0; k < 10; k++) begin
            bus.step_seq = 1'b1;
            push_term();
            @(negedge clkslow_tb);
            t = term_q.pop_front();
            checks++;
            if (bus.ena_seq !== 1'b1 || bus.addr_ar_seq !== t.ar || bus.addr_br_seq !== t.br) begin
                errors++;
                $display("FAIL mid_term_%0d: ena=%b ar=%0d br=%0d, want 1 %0d %0d", k,
                         bus.ena_seq, bus.addr_ar_seq, bus.addr_br_seq, t.ar, t.br);
            end
        end
        bus.step_seq = 1'b0;
        #2 rst_n_tb = 1'b0;
        #1;
        checks++;
        if ({bus.ena_seq, bus.clr_seq, bus.busy_seq, bus.done_seq, bus.ovf_seq, bus.res_valid_seq} !== 6'b0 ||
            {bus.addr_ar_seq, bus.addr_ai_seq, bus.addr_br_seq, bus.addr_bi_seq} !== 20'b0 ||
            bus.res_data_seq !== 32'sd0 || bus.res_row_seq !== 2'd0 || bus.res_col_seq !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: ena=%b busy=%b ovf=%b valid=%b ar=%0d br=%0d data=%h, want all 0",
                     bus.ena_seq, bus.busy_seq, bus.ovf_seq, bus.res_valid_seq, bus.addr_ar_seq,
                     bus.addr_br_seq, bus.res_data_seq);
        end
        @(negedge clkslow_tb);
        rst_n_tb = 1'b1;
    endtask

    task automatic test_step4();
        term_t t;
        term_t last_t;
        model_restart();
        @(negedge clkslow_tb); bus.start_seq = 1'b1;
        @(negedge clkslow_tb); bus.start_seq = 1'b0;
        last_t = '{ar: '0, ai: '0, br: '0, bi: '0, clr: 1'b0};
        for (int k = 0; k < 27 * 4; k++) begin
            bus.step_seq = (k % 4 == 0);
            if (k % 4 == 0) push_term();
            @(negedge clkslow_tb);
            checks++;
            if (k % 4 == 0) begin
                t = term_q.pop_front();
                last_t = t;
                if (bus.ena_seq !== 1'b1 || bus.clr_seq !== t.clr || bus.addr_ar_seq !== t.ar ||
                    bus.addr_ai_seq !== t.ai || bus.addr_br_seq !== t.br || bus.addr_bi_seq !== t.bi) begin
                    errors++;
                    $display("FAIL step4_term_%0d: ena=%b clr=%b ar=%0d ai=%0d br=%0d bi=%0d, want 1 %b %0d %0d %0d %0d",
                             k / 4, bus.ena_seq, bus.clr_seq, bus.addr_ar_seq, bus.addr_ai_seq,
                             bus.addr_br_seq, bus.addr_bi_seq, t.clr, t.ar, t.ai, t.br, t.bi);
                end
            end else if (bus.ena_seq !== 1'b0 || bus.clr_seq !== 1'b0 || bus.addr_ar_seq !== last_t.ar ||
                         bus.addr_ai_seq !== last_t.ai || bus.addr_br_seq !== last_t.br ||
                         bus.addr_bi_seq !== last_t.bi) begin
                errors++;
                $display("FAIL step4_hold_%0d: ena=%b clr=%b ar=%0d br=%0d, want 0 0 %0d %0d", k,
                         bus.ena_seq, bus.clr_seq, bus.addr_ar_seq, bus.addr_br_seq, last_t.ar, last_t.br);
            end
            if (k == 0) begin
                checks++;
                if (bus.addr_ar_seq !== 5'd0 || bus.addr_br_seq !== 5'd0 || bus.clr_seq !== 1'b1) begin
                    errors++;
                    $display("FAIL restart_first: ar=%0d br=%0d clr=%b, want 0 0 1", bus.addr_ar_seq,
                             bus.addr_br_seq, bus.clr_seq);
                end
            end
        end
        bus.step_seq = 1'b0;
    endtask

    initial begin
        bus.start_seq     = 1'b0;
        bus.step_seq      = 1'b0;
        bus.flag_seq      = 1'b0;
        bus.acc_seq       = '0;
        bus.res_ready_seq = 1'b0;
        test_reset();
        test_full_pass();
        test_results();
        test_overflow();
        test_reset_midpass();
        test_step4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
